// File: rtl/data_mem_arb_pkg.sv
// Shared types for the data_mem arbiter: FSM states and port ids.
// Optional round-robin arbitration is enabled by DATA_MEM_ARB_RR_EN.
package data_mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_LDR = 1'b1;

endpackage

// File: rtl/data_mem_arb_sel.sv
// Winner selection among eligible requests.
// DATA_MEM_ARB_RR_EN selects round-robin; otherwise port 0 wins ties.
module data_mem_arb_sel
   import data_mem_arb_pkg::*;
(
   input  logic [1:0] elig,
`ifdef DATA_MEM_ARB_RR_EN
   input  logic       last,
`endif
   output logic       valid,
   output logic       id
);

   assign valid = |elig;

`ifdef DATA_MEM_ARB_RR_EN
   always_comb begin
      id = PORT_CPU;
      if (&elig)
         id = ~last;
      else if (elig[PORT_LDR])
         id = PORT_LDR;
   end
`else
   assign id = elig[PORT_CPU] ? PORT_CPU : PORT_LDR;
`endif

endmodule

// File: rtl/data_mem_arb.sv
// Two-port arbiter/sequencer in front of the single-port data_mem.
// Define DATA_MEM_ARB_RR_EN for round-robin tie breaking.
module data_mem_arb
   import data_mem_arb_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic             req1,
   input  logic             we0,
   input  logic             we1,
   input  logic [WIDTH-1:0] addr0,
   input  logic [WIDTH-1:0] addr1,
   input  logic [WIDTH-1:0] wdata0,
   input  logic [WIDTH-1:0] wdata1,
   output logic             ack0,
   output logic             ack1,
   output logic [WIDTH-1:0] rdata0,
   output logic [WIDTH-1:0] rdata1,
   output logic             mem_en,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_d_in,
   input  logic [WIDTH-1:0] mem_d_out
);

   state_t           state;
   state_t           state_nx;
   logic             gnt_q;
   logic             we_q;
   logic [1:0]       elig;
   logic             win_valid;
   logic             win_id;
   logic             win_we;
   logic [WIDTH-1:0] win_addr;
   logic [WIDTH-1:0] win_wdata;

   // A port's req is masked in its own ack cycle so a late drop is not re-granted
   assign elig = {req1 & ~ack1, req0 & ~ack0};

`ifdef DATA_MEM_ARB_RR_EN
   logic last_q;

   always_ff @(posedge clk) begin
      if (rst)
         last_q <= PORT_LDR;
      else if (state == IDLE && win_valid)
         last_q <= win_id;
   end

   data_mem_arb_sel u_sel (
      .elig  (elig),
      .last  (last_q),
      .valid (win_valid),
      .id    (win_id)
   );
`else
   data_mem_arb_sel u_sel (
      .elig  (elig),
      .valid (win_valid),
      .id    (win_id)
   );
`endif

   assign win_we    = (win_id == PORT_LDR) ? we1    : we0;
   assign win_addr  = (win_id == PORT_LDR) ? addr1  : addr0;
   assign win_wdata = (win_id == PORT_LDR) ? wdata1 : wdata0;

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (win_valid) state_nx = ACCESS;
         ACCESS:  state_nx = RESP;
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         gnt_q    <= PORT_CPU;
         we_q     <= 1'b0;
         ack0     <= 1'b0;
         ack1     <= 1'b0;
         rdata0   <= '0;
         rdata1   <= '0;
         mem_en   <= 1'b0;
         mem_addr <= '0;
         mem_d_in <= '0;
      end else begin
         ack0 <= 1'b0;
         ack1 <= 1'b0;
         case (state)
            IDLE: begin
               if (win_valid) begin
                  gnt_q    <= win_id;
                  we_q     <= win_we;
                  mem_en   <= win_we;
                  mem_addr <= win_addr;
                  mem_d_in <= win_wdata;
               end
            end
            ACCESS: mem_en <= 1'b0;
            RESP: begin
               if (gnt_q == PORT_LDR) begin
                  ack1 <= 1'b1;
                  if (!we_q) rdata1 <= mem_d_out;
               end else begin
                  ack0 <= 1'b1;
                  if (!we_q) rdata0 <= mem_d_out;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_arb.sv
// Directed self-checking bench for data_mem_arb with a behavioural data_mem.
// Covers both builds; tie expectations follow DATA_MEM_ARB_RR_EN.
module tb_data_mem_arb;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req0 = 1'b0, req1 = 1'b0;
   logic       we0 = 1'b0, we1 = 1'b0;
   logic [7:0] addr0 = '0, addr1 = '0;
   logic [7:0] wdata0 = '0, wdata1 = '0;
   logic       ack0, ack1;
   logic [7:0] rdata0, rdata1;
   logic       mem_en;
   logic [7:0] mem_addr, mem_d_in;
   logic [7:0] mem_d_out = '0;

   logic [7:0] mem [256];

   int checks = 0;
   int passed = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   // Behavioural data_mem: write strobe and registered read.
   always @(posedge clk) begin
      if (mem_en) mem[mem_addr] <= mem_d_in;
      mem_d_out <= mem[mem_addr];
   end

   data_mem_arb #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .req0      (req0),
      .req1      (req1),
      .we0       (we0),
      .we1       (we1),
      .addr0     (addr0),
      .addr1     (addr1),
      .wdata0    (wdata0),
      .wdata1    (wdata1),
      .ack0      (ack0),
      .ack1      (ack1),
      .rdata0    (rdata0),
      .rdata1    (rdata1),
      .mem_en    (mem_en),
      .mem_addr  (mem_addr),
      .mem_d_in  (mem_d_in),
      .mem_d_out (mem_d_out)
   );

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One transaction; req dropped right after the grant edge.
   task automatic txn(input bit p, input bit w, input logic [7:0] a,
                      input logic [7:0] d, input logic [7:0] exp);
      @(negedge clk);
      if (p) begin req1 = 1; we1 = w; addr1 = a; wdata1 = d; end
      else   begin req0 = 1; we0 = w; addr0 = a; wdata0 = d; end
      @(negedge clk);
      req0 = 0; req1 = 0;
      addr0 = ~a; addr1 = ~a; wdata0 = ~d; wdata1 = ~d;
      chk("en_access", 8'(mem_en), 8'(w));
      chk("addr_access", mem_addr, a);
      @(negedge clk);
      chk("en_resp", 8'(mem_en), 8'h00);
      chk("ack_early", 8'({ack1, ack0}), 8'h00);
      @(negedge clk);
      chk("ack", 8'({ack1, ack0}), p ? 8'h02 : 8'h01);
      if (!w) chk("rdata", p ? rdata1 : rdata0, exp);
   endtask

   // Both ports write at once and hold req until their own ack.
   task automatic tie(input bit first);
      int t0, t1;
      t0 = -1; t1 = -1;
      @(negedge clk);
      req0 = 1; we0 = 1; addr0 = 8'h01; wdata0 = 8'h11;
      req1 = 1; we1 = 1; addr1 = 8'h02; wdata1 = 8'h22;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (ack0 && ack1) chk("ack_both", 8'h03, 8'h00);
         if (ack0) begin t0 = i; req0 = 0; end
         if (ack1) begin t1 = i; req1 = 0; end
      end
      req0 = 0; req1 = 0;
      chk("tie_t0", 8'(t0), first ? 8'd6 : 8'd3);
      chk("tie_t1", 8'(t1), first ? 8'd3 : 8'd6);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_ack", 8'({ack1, ack0}), 8'h00);
      chk("rst_en", 8'(mem_en), 8'h00);
      chk("rst_addr", mem_addr, 8'h00);
      chk("rst_din", mem_d_in, 8'h00);
      chk("rst_rdata0", rdata0, 8'h00);
      chk("rst_rdata1", rdata1, 8'h00);
      rst = 0;

      // first tie after reset: port 0 wins in both builds
      tie(1'b0);
      txn(1'b0, 1'b0, 8'h01, 8'h00, 8'h11);
      txn(1'b1, 1'b0, 8'h02, 8'h00, 8'h22);
      txn(1'b0, 1'b0, 8'h02, 8'h00, 8'h22);
`ifdef DATA_MEM_ARB_RR_EN
      tie(1'b1);
`else
      tie(1'b0);
`endif

      // loader write, then CPU read back
      txn(1'b1, 1'b1, 8'h10, 8'hA5, 8'h00);
      txn(1'b0, 1'b0, 8'h10, 8'h00, 8'hA5);

      // req0 held one cycle past its ack: exactly one pulse
      begin
         int pulses;
         pulses = 0;
         @(negedge clk);
         req0 = 1; we0 = 0; addr0 = 8'h10;
         for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ack0) pulses++;
            if (i == 3) req0 = 0;
         end
         chk("hold_pulses", 8'(pulses), 8'd1);
         chk("hold_rdata", rdata0, 8'hA5);
      end

      // reset in ACCESS of a write: memory commits, no ack
      @(negedge clk);
      req1 = 1; we1 = 1; addr1 = 8'h20; wdata1 = 8'h5A;
      @(negedge clk);
      req1 = 0;
      chk("rst_wr_en", 8'(mem_en), 8'h01);
      rst = 1;
      @(negedge clk);
      rst = 0;
      chk("rstacc_en", 8'(mem_en), 8'h00);
      chk("rstacc_addr", mem_addr, 8'h00);
      chk("rstacc_din", mem_d_in, 8'h00);
      chk("rstacc_rdata0", rdata0, 8'h00);
      begin
         int acks;
         acks = 0;
         for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ack0 || ack1) acks++;
         end
         chk("rstacc_noack", 8'(acks), 8'd0);
      end
      txn(1'b0, 1'b0, 8'h20, 8'h00, 8'h5A);

      // full address sweep including 8'hFF
      for (int a = 0; a < 256; a++)
         txn(1'b1, 1'b1, 8'(a), 8'(a * 5), 8'h00);
      for (int a = 0; a < 256; a++)
         txn(1'b0, 1'b0, 8'(a), 8'h00, 8'(a * 5));

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
